apb_led_sw_ctrl: RTL and testbench
==================================

// Module: apb_led_sw_ctrl
// PURPOSE
//  APB3 slave peripheral on the SoC io_apbSlave port. It replaces direct GPIO wiring of LEDs and switches.
//  - Drives LED_N LEDs; each LED is either static or PWM-dimmed from a shared duty register.
//  - Synchronises and debounces SW_N switch inputs.
//  - Raises a maskable level interrupt on debounced switch rising edges.
// PARAMETERS
//  ADDR_W   16     APB address width (only PADDR[4:2] decoded)
//  LED_N    8      number of LED outputs, 1..32
//  SW_N     1      number of switch inputs, 1..32
//  DEB_CYC  1000   stable cycles required to accept a switch change, >=1
//  PWM_W    8      PWM counter/duty width, 1..16
// PORTS
//  io_systemClk        in   1        single clock
//  io_systemReset      in   1        synchronous reset, active-high
//  io_apbSlave_PADDR   in   ADDR_W   APB address
//  io_apbSlave_PSEL    in   1        APB select
//  io_apbSlave_PENABLE in   1        APB access phase
//  io_apbSlave_PWRITE  in   1        1=write
//  io_apbSlave_PWDATA  in   32       write data
//  io_apbSlave_PRDATA  out  32       read data
//  io_apbSlave_PREADY  out  1        transfer ready
//  io_apbSlave_PSLVERROR out 1       error response
//  i_sw                in   SW_N     raw async switch inputs
//  o_led               out  LED_N    LED drive, 1=on
//  o_irq               out  1        level interrupt, active-high
// BEHAVIOUR
//  Reset values:
//  - All registers are 0, and the debounced switch state is 0.
//  - PWM counter is 0, o_led=0, o_irq=0.
//  - PRDATA=0 and PSLVERROR=0 while no access is in progress.
//  APB transfers:
//  - Zero wait states; PREADY is constantly 1.
//  - A write commits on the cycle where PSEL&PENABLE&PWRITE are all high.
//  - Read data is combinational during PSEL&PENABLE and 0 otherwise.
//  Register map (offset, access, contents; unused bits read 0):
//   0x00 LED_OUT  RW [LED_N-1:0] static LED value
//   0x04 LED_MODE RW [LED_N-1:0] per-LED mode; 1=PWM, 0=static
//   0x08 PWM_DUTY RW [PWM_W-1:0] shared duty
//   0x0C SW_IN    RO [SW_N-1:0] debounced switch state
//   0x10 IRQ_EN   RW [SW_N-1:0] interrupt enables
//   0x14 IRQ_STAT W1C [SW_N-1:0] sticky edge flags
//   0x18 ID       RO 32'h4C_53_00_01
//   0x1C          unmapped
//  Errors:
//  - PSLVERROR is asserted at 0x1C, at any address with PADDR[1:0]!=0, or at any address above 0x1C.
//  - Such an access has no register side effect, and a read of it returns 0.
//  - Writes to RO registers are ignored without error.
//  Switch synchroniser and debounce, per switch:
//  - Raw input passes a 2-FF synchroniser, then a counter.
//  - Counter increments while the synced value != debounced value and clears whenever they are equal.
//  - When the count reaches DEB_CYC-1, the debounced value takes the synced value and the counter clears.
//  - Step latency from i_sw to SW_IN is 2+DEB_CYC cycles; a glitch shorter than DEB_CYC cycles is ignored.
//  Interrupt flags:
//  - A debounced 0->1 transition sets the IRQ_STAT bit, regardless of IRQ_EN.
//  - If a W1C clear and a new edge hit the same bit in the same cycle, set wins.
//  - o_irq is registered: |(IRQ_STAT & IRQ_EN), so it rises 1 cycle after the flag is set.
//  PWM:
//  - pwm_cnt is free-running and wraps from 2^PWM_W-1 to 0.
//  - pwm_on = (pwm_cnt < PWM_DUTY). Duty 0 gives always off; duty max gives on (2^PWM_W-1)/2^PWM_W of the time.
//  - o_led[i] is registered from LED_MODE[i] ? pwm_on : LED_OUT[i], so a register write is visible on o_led 1 cycle later.
//  Reset mid-operation clears everything at once:
//  - Debounce counters in progress are discarded.
//  - Pending flags are dropped, and o_irq falls on the next edge.
// TESTING
//  1. Reset, then read each register -> all 0, except ID=32'h4C530001; PSLVERROR=0 throughout.
//  2. Write LED_OUT=0xA5, LED_MODE=0 -> o_led=0xA5 one cycle after the access-phase edge.
//  3. PWM_W=8, LED_MODE=0x01, PWM_DUTY=64 -> o_led[0] high exactly 64 of every 256 cycles; duty 0 -> never high.
//  4. DEB_CYC=1000: pulse i_sw high for 500 cycles -> SW_IN stays 0, no flag.
//     Hold i_sw high -> SW_IN=1 at cycle 1002, IRQ_STAT[0]=1, o_irq=1 one cycle later (IRQ_EN=1).
//  5. W1C write 1 to IRQ_STAT[0] in the same cycle as a new debounced edge -> flag stays 1, o_irq stays 1.
//  6. Read 0x1C, write 0x20, write 0x02 -> PSLVERROR=1, PRDATA=0, no register changes.
//     Then assert reset mid-debounce -> SW_IN=0, o_irq=0.

Source files
------------

// File: rtl/apb_led_sw_ctrl_if.sv
// APB3 bus bundle for the LED/switch controller; the master side drives
// address, control and write data, the slave side returns data and status.
interface apb_led_sw_ctrl_if #(
    parameter int ADDR_W = 16
) ();
    logic [ADDR_W-1:0] PADDR;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [31:0]       PWDATA;
    logic [31:0]       PRDATA;
    logic              PREADY;
    logic              PSLVERROR;

    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERROR
    );

    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERROR
    );
endinterface

// File: rtl/apb_led_sw_ctrl.sv
// APB3 LED/switch peripheral: static or PWM-dimmed LEDs, debounced switches
// and a maskable level interrupt on debounced switch rising edges.
module apb_led_sw_ctrl #(
    parameter int ADDR_W  = 16,
    parameter int LED_N   = 8,
    parameter int SW_N    = 1,
    parameter int DEB_CYC = 1000,
    parameter int PWM_W   = 8
) (
    input  logic               io_systemClk,
    input  logic               io_systemReset,
    apb_led_sw_ctrl_if.slave   io_apbSlave,
    input  logic [SW_N-1:0]    i_sw,
    output logic [LED_N-1:0]   o_led,
    output logic               o_irq
);
    localparam int              DEB_W   = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYC - 1);
    localparam logic [31:0]     ID_VAL  = 32'h4C53_0001;

    logic [LED_N-1:0]  led_out, led_mode;
    logic [PWM_W-1:0]  pwm_duty, pwm_cnt;
    logic [SW_N-1:0]   irq_en, irq_stat;
    logic [SW_N-1:0]   sw_meta, sw_sync, sw_deb;
    logic [SW_N-1:0]   deb_flip, rise, w1c;
    logic [DEB_W-1:0]  deb_cnt [SW_N];

    logic [ADDR_W-1:0] addr;
    logic [2:0]        sel;
    logic              access, addr_err, wr_en, pwm_on;
    logic [31:0]       rdata;
    logic              unused_wdata;

    assign addr     = io_apbSlave.PADDR;
    assign sel      = addr[4:2];
    assign access   = io_apbSlave.PSEL & io_apbSlave.PENABLE;
    // 0x1C and everything above it is outside the register file
    assign addr_err = (addr[1:0] != 2'b00) || (addr > ADDR_W'(24));
    assign wr_en    = access & io_apbSlave.PWRITE & ~addr_err;
    assign w1c      = (wr_en && sel == 3'd5) ? io_apbSlave.PWDATA[SW_N-1:0] : '0;
    assign pwm_on   = pwm_cnt < pwm_duty;
    assign unused_wdata = ^io_apbSlave.PWDATA;

    for (genvar i = 0; i < SW_N; i++) begin : g_flip
        assign deb_flip[i] = (sw_sync[i] != sw_deb[i]) && (deb_cnt[i] == DEB_MAX);
    end
    assign rise = deb_flip & sw_sync;

    always_ff @(posedge io_systemClk) begin
        if (io_systemReset) begin
            led_out  <= '0;
            led_mode <= '0;
            pwm_duty <= '0;
            pwm_cnt  <= '0;
            irq_en   <= '0;
            irq_stat <= '0;
            sw_meta  <= '0;
            sw_sync  <= '0;
            sw_deb   <= '0;
            o_led    <= '0;
            o_irq    <= 1'b0;
            for (int i = 0; i < SW_N; i++) deb_cnt[i] <= '0;
        end else begin
            sw_meta <= i_sw;
            sw_sync <= sw_meta;
            sw_deb  <= sw_deb ^ deb_flip;
            for (int i = 0; i < SW_N; i++) begin
                if (sw_sync[i] == sw_deb[i] || deb_flip[i])
                    deb_cnt[i] <= '0;
                else
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
            pwm_cnt  <= pwm_cnt + 1'b1;
            o_led    <= (led_mode & {LED_N{pwm_on}}) | (~led_mode & led_out);
            o_irq    <= |(irq_stat & irq_en);
            // a new edge overrides a simultaneous W1C on the same bit
            irq_stat <= (irq_stat & ~w1c) | rise;
            if (wr_en) begin
                case (sel)
                    3'd0:    led_out  <= io_apbSlave.PWDATA[LED_N-1:0];
                    3'd1:    led_mode <= io_apbSlave.PWDATA[LED_N-1:0];
                    3'd2:    pwm_duty <= io_apbSlave.PWDATA[PWM_W-1:0];
                    3'd4:    irq_en   <= io_apbSlave.PWDATA[SW_N-1:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (access && !addr_err) begin
            case (sel)
                3'd0:    rdata[LED_N-1:0] = led_out;
                3'd1:    rdata[LED_N-1:0] = led_mode;
                3'd2:    rdata[PWM_W-1:0] = pwm_duty;
                3'd3:    rdata[SW_N-1:0]  = sw_deb;
                3'd4:    rdata[SW_N-1:0]  = irq_en;
                3'd5:    rdata[SW_N-1:0]  = irq_stat;
                3'd6:    rdata            = ID_VAL;
                default: rdata            = '0;
            endcase
        end
    end

    assign io_apbSlave.PRDATA    = rdata;
    assign io_apbSlave.PREADY    = 1'b1;
    assign io_apbSlave.PSLVERROR = access & addr_err;
endmodule

// File: tb/tb_apb_led_sw_ctrl.sv
// Bench for apb_led_sw_ctrl: register table, hand-timed corner sequences and
// randomized traffic checked against a cycle-level behavioural model.
module tb_apb_led_sw_ctrl;
    localparam int ADDR_W  = 16;
    localparam int LED_N   = 8;
    localparam int SW_N    = 2;
    localparam int DEB_CYC = 1000;
    localparam int PWM_W   = 8;
    localparam logic [31:0] ID_VAL = 32'h4C530001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [SW_N-1:0]  sw = '0;
    logic [LED_N-1:0] o_led;
    logic             o_irq;

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    apb_led_sw_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    apb_led_sw_ctrl #(
        .ADDR_W(ADDR_W), .LED_N(LED_N), .SW_N(SW_N), .DEB_CYC(DEB_CYC), .PWM_W(PWM_W)
    ) dut (
        .io_systemClk(clk),
        .io_systemReset(rst),
        .io_apbSlave(bus),
        .i_sw(sw),
        .o_led(o_led),
        .o_irq(o_irq)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [LED_N-1:0] m_out, m_mode, m_led_exp;
    logic [PWM_W-1:0] m_duty;
    logic [SW_N-1:0]  m_en, m_stat, m_deb, m_rise, m_w1c;
    logic             m_irq_exp;
    int               m_cyc;
    logic [SW_N-1:0]  hist[$];   // raw switch samples, oldest first
    bit               all_diff, pon;

    function automatic bit addr_ok(input logic [ADDR_W-1:0] a);
        return (a[1:0] == 2'b00) && (a <= 16'h18);
    endfunction

    function automatic logic [31:0] model_read(input logic [ADDR_W-1:0] a);
        if (!addr_ok(a)) return 32'h0;
        case (a)
            16'h00:  return 32'(m_out);
            16'h04:  return 32'(m_mode);
            16'h08:  return 32'(m_duty);
            16'h0C:  return 32'(m_deb);
            16'h10:  return 32'(m_en);
            16'h14:  return 32'(m_stat);
            16'h18:  return ID_VAL;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_out = '0; m_mode = '0; m_duty = '0; m_en = '0; m_stat = '0; m_deb = '0;
            m_led_exp = '0; m_irq_exp = 1'b0; m_cyc = 0;
            hist.delete();
            for (int k = 0; k <= DEB_CYC; k++) hist.push_back('0);
        end else begin
            pon = (m_cyc % (1 << PWM_W)) < int'(m_duty);
            for (int b = 0; b < LED_N; b++) m_led_exp[b] = m_mode[b] ? pon : m_out[b];
            m_irq_exp = |(m_stat & m_en);
            // switch accepted once its synchronised value has differed for DEB_CYC straight cycles
            m_rise = '0;
            for (int i = 0; i < SW_N; i++) begin
                all_diff = 1'b1;
                for (int k = 0; k < DEB_CYC; k++) if (hist[k][i] == m_deb[i]) all_diff = 1'b0;
                if (all_diff) begin
                    m_deb[i] = ~m_deb[i];
                    m_rise[i] = m_deb[i];
                end
            end
            void'(hist.pop_front());
            hist.push_back(sw);
            m_w1c = '0;
            if (bus.PSEL && bus.PENABLE && bus.PWRITE && addr_ok(bus.PADDR)) begin
                case (bus.PADDR)
                    16'h00: m_out  = bus.PWDATA[LED_N-1:0];
                    16'h04: m_mode = bus.PWDATA[LED_N-1:0];
                    16'h08: m_duty = bus.PWDATA[PWM_W-1:0];
                    16'h10: m_en   = bus.PWDATA[SW_N-1:0];
                    16'h14: m_w1c  = bus.PWDATA[SW_N-1:0];
                    default: ;
                endcase
            end
            m_stat = (m_stat & ~m_w1c) | m_rise;
            m_cyc++;
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("o_led_model", 32'(o_led), 32'(m_led_exp));
            chk("o_irq_model", 32'(o_irq), 32'(m_irq_exp));
        end
    end

    // One APB transfer, entered and left on a negedge; response sampled in the access phase.
    task automatic apb(input logic [ADDR_W-1:0] a, input logic w, input logic [31:0] d,
                       input logic [31:0] exp_rd, input logic exp_err, input bit use_model,
                       input string name);
        logic [31:0] er;
        logic        ee;
        bus.PADDR = a; bus.PWRITE = w; bus.PWDATA = d; bus.PSEL = 1'b1; bus.PENABLE = 1'b0;
        @(negedge clk);
        bus.PENABLE = 1'b1;
        #1;
        er = use_model ? model_read(a) : exp_rd;
        ee = use_model ? !addr_ok(a) : exp_err;
        chk({name, "_err"}, 32'(bus.PSLVERROR), 32'(ee));
        chk({name, "_rdy"}, 32'(bus.PREADY), 32'd1);
        if (!w) chk({name, "_rd"}, bus.PRDATA, er);
        @(posedge clk);
        @(negedge clk);
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    endtask

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              wr;
        logic [31:0]       wdata;
        logic [31:0]       rd;
        logic              err;
    } vec_t;
    vec_t tbl[29];

    logic [ADDR_W-1:0] rnd_addr[12];
    int hi, n;
    logic [ADDR_W-1:0] ra;

    initial begin
        tbl[0]  = '{16'h0000, 1'b0, 32'h0,        32'h0,        1'b0};
        tbl[1]  = '{16'h0004, 1'b0, 32'h0,        32'h0,        1'b0};
        tbl[2]  = '{16'h0008, 1'b0, 32'h0,        32'h0,        1'b0};
        tbl[3]  = '{16'h000C, 1'b0, 32'h0,        32'h0,        1'b0};
        tbl[4]  = '{16'h0010, 1'b0, 32'h0,        32'h0,        1'b0};
        tbl[5]  = '{16'h0014, 1'b0, 32'h0,        32'h0,        1'b0};
        tbl[6]  = '{16'h0018, 1'b0, 32'h0,        ID_VAL,       1'b0};
        tbl[7]  = '{16'h001C, 1'b0, 32'h0,        32'h0,        1'b1};
        tbl[8]  = '{16'h0000, 1'b1, 32'hFFFFFFFF, 32'h0,        1'b0};
        tbl[9]  = '{16'h0000, 1'b0, 32'h0,        32'hFF,       1'b0};
        tbl[10] = '{16'h0004, 1'b1, 32'hFFFFFF3C, 32'h0,        1'b0};
        tbl[11] = '{16'h0004, 1'b0, 32'h0,        32'h3C,       1'b0};
        tbl[12] = '{16'h0008, 1'b1, 32'h00012345, 32'h0,        1'b0};
        tbl[13] = '{16'h0008, 1'b0, 32'h0,        32'h45,       1'b0};
        tbl[14] = '{16'h0010, 1'b1, 32'hFFFFFFFF, 32'h0,        1'b0};
        tbl[15] = '{16'h0010, 1'b0, 32'h0,        32'h3,        1'b0};
        tbl[16] = '{16'h000C, 1'b1, 32'hFFFFFFFF, 32'h0,        1'b0};
        tbl[17] = '{16'h000C, 1'b0, 32'h0,        32'h0,        1'b0};
        tbl[18] = '{16'h0018, 1'b1, 32'h0,        32'h0,        1'b0};
        tbl[19] = '{16'h0018, 1'b0, 32'h0,        ID_VAL,       1'b0};
        tbl[20] = '{16'h0002, 1'b1, 32'h0,        32'h0,        1'b1};
        tbl[21] = '{16'h0020, 1'b0, 32'h0,        32'h0,        1'b1};
        tbl[22] = '{16'hFFFC, 1'b0, 32'h0,        32'h0,        1'b1};
        tbl[23] = '{16'h0014, 1'b1, 32'h3,        32'h0,        1'b0};
        tbl[24] = '{16'h0014, 1'b0, 32'h0,        32'h0,        1'b0};
        tbl[25] = '{16'h0000, 1'b1, 32'h0,        32'h0,        1'b0};
        tbl[26] = '{16'h0004, 1'b1, 32'h0,        32'h0,        1'b0};
        tbl[27] = '{16'h0008, 1'b1, 32'h0,        32'h0,        1'b0};
        tbl[28] = '{16'h0010, 1'b1, 32'h0,        32'h0,        1'b0};
        rnd_addr = '{16'h00, 16'h04, 16'h08, 16'h0C, 16'h10, 16'h14,
                     16'h18, 16'h1C, 16'h20, 16'h02, 16'h16, 16'hFFFC};

        bus.PADDR = '0; bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PWDATA = '0;
        repeat (3) @(negedge clk);
        chk("rst_led", 32'(o_led), 32'h0);
        chk("rst_irq", 32'(o_irq), 32'h0);
        chk("idle_prdata", bus.PRDATA, 32'h0);
        chk("idle_err", 32'(bus.PSLVERROR), 32'h0);
        rst = 1'b0;
        chk_on = 1'b1;
        @(negedge clk);

        // register table
        for (int i = 0; i < 29; i++)
            apb(tbl[i].addr, tbl[i].wr, tbl[i].wdata, tbl[i].rd, tbl[i].err, 1'b0,
                $sformatf("tbl%0d", i));

        // static LED write lands one cycle after the access edge
        apb(16'h00, 1'b1, 32'hA5, 0, 0, 1'b0, "led_wr");
        chk("led_before", 32'(o_led), 32'h00);
        @(negedge clk);
        chk("led_after", 32'(o_led), 32'hA5);

        // PWM duty cycles on LED0
        apb(16'h08, 1'b1, 32'd64, 0, 0, 1'b0, "duty64");
        apb(16'h04, 1'b1, 32'h01, 0, 0, 1'b0, "mode1");
        @(negedge clk);
        hi = 0;
        for (int c = 0; c < 256; c++) begin hi += int'(o_led[0]); @(negedge clk); end
        chk("pwm_duty64", 32'(hi), 32'd64);
        apb(16'h08, 1'b1, 32'd0, 0, 0, 1'b0, "duty0");
        @(negedge clk);
        hi = 0;
        for (int c = 0; c < 256; c++) begin hi += int'(o_led[0]); @(negedge clk); end
        chk("pwm_duty0", 32'(hi), 32'd0);
        apb(16'h08, 1'b1, 32'd255, 0, 0, 1'b0, "duty255");
        @(negedge clk);
        hi = 0;
        for (int c = 0; c < 256; c++) begin hi += int'(o_led[0]); @(negedge clk); end
        chk("pwm_duty255", 32'(hi), 32'd255);
        apb(16'h04, 1'b1, 32'h00, 0, 0, 1'b0, "mode0");

        // short glitch is rejected
        apb(16'h10, 1'b1, 32'h1, 0, 0, 1'b0, "irq_en1");
        sw[0] = 1'b1;
        repeat (500) @(negedge clk);
        sw[0] = 1'b0;
        repeat (1100) @(negedge clk);
        apb(16'h0C, 1'b0, 0, 32'h0, 0, 1'b0, "glitch_swin");
        apb(16'h14, 1'b0, 0, 32'h0, 0, 1'b0, "glitch_stat");
        chk("glitch_irq", 32'(o_irq), 32'h0);

        // held input: debounced at edge 1002, o_irq at 1003
        sw[0] = 1'b1;
        repeat (1000) @(negedge clk);
        apb(16'h0C, 1'b0, 0, 32'h0, 0, 1'b0, "swin_1001");
        chk("irq_1002", 32'(o_irq), 32'h0);
        @(negedge clk);
        chk("irq_1003", 32'(o_irq), 32'h1);
        apb(16'h0C, 1'b0, 0, 32'h1, 0, 1'b0, "swin_held");
        apb(16'h14, 1'b0, 0, 32'h1, 0, 1'b0, "stat_held");

        // W1C colliding with a fresh edge: set wins
        sw[0] = 1'b0;
        repeat (1100) @(negedge clk);
        apb(16'h14, 1'b0, 0, 32'h1, 0, 1'b0, "stat_sticky");
        sw[0] = 1'b1;
        repeat (1000) @(negedge clk);
        apb(16'h14, 1'b1, 32'h1, 0, 0, 1'b0, "w1c_collide");
        chk("collide_irq0", 32'(o_irq), 32'h1);
        @(negedge clk);
        chk("collide_irq1", 32'(o_irq), 32'h1);
        apb(16'h14, 1'b0, 0, 32'h1, 0, 1'b0, "collide_stat");
        apb(16'h14, 1'b1, 32'h1, 0, 0, 1'b0, "w1c_plain");
        @(negedge clk);
        chk("w1c_irq", 32'(o_irq), 32'h0);
        apb(16'h14, 1'b0, 0, 32'h0, 0, 1'b0, "w1c_stat");

        // error accesses have no side effects
        apb(16'h20, 1'b1, 32'hFFFFFFFF, 0, 1'b1, 1'b0, "err_w20");
        apb(16'h02, 1'b1, 32'hFFFFFFFF, 0, 1'b1, 1'b0, "err_w02");
        apb(16'h1C, 1'b1, 32'hFFFFFFFF, 0, 1'b1, 1'b0, "err_w1c");
        apb(16'h1C, 1'b0, 0, 32'h0, 1'b1, 1'b0, "err_r1c");
        apb(16'h00, 1'b0, 0, 32'hA5, 1'b0, 1'b0, "err_led");
        apb(16'h04, 1'b0, 0, 32'h00, 1'b0, 1'b0, "err_mode");

        // reset in the middle of a debounce
        apb(16'h10, 1'b1, 32'h3, 0, 0, 1'b0, "irq_en3");
        sw[1] = 1'b1;
        repeat (1003) @(negedge clk);
        chk("pre_rst_irq", 32'(o_irq), 32'h1);
        sw[1] = 1'b0;
        repeat (500) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_irq", 32'(o_irq), 32'h0);
        chk("rst_mid_led", 32'(o_led), 32'h0);
        rst = 1'b0;
        apb(16'h0C, 1'b0, 0, 32'h0, 0, 1'b0, "rst_swin");
        apb(16'h14, 1'b0, 0, 32'h0, 0, 1'b0, "rst_stat");
        apb(16'h10, 1'b0, 0, 32'h0, 0, 1'b0, "rst_en");
        apb(16'h00, 1'b0, 0, 32'h0, 0, 1'b0, "rst_ledout");

        // randomized traffic against the model
        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 2) == 0) sw = SW_N'($urandom_range(0, 3));
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(900, 1200) : $urandom_range(0, 40);
            repeat (n) @(negedge clk);
            ra = rnd_addr[$urandom_range(0, 11)];
            apb(ra, 1'($urandom_range(0, 1)), $urandom, 0, 0, 1'b1, "rnd");
        end

        repeat (4) @(negedge clk);
        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
